// File: rtl/ras_pkg.sv
// Shared types for the return-address-stack controller: FSM state, stack command bundle,
// statistics counter width and a saturating-add helper.
package ras_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPEC    = 2'd1,
        RECOVER = 2'd2
    } ras_ctrl_state_e;

    typedef struct packed {
        logic push;
        logic pop;
        logic branch;
        logic close_valid;
        logic close_invalid;
    } ras_cmd_t;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a, input logic [1:0] inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {{(STAT_W-1){1'b0}}, inc};
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/ras_ctrl_stats.sv
// Saturating statistics counter bank for ras_ctrl; only instantiated when
// RAS_CTRL_STATS_EN is defined.
module ras_ctrl_stats
    import ras_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_calls,
    input  logic              inc_rets,
    input  logic [1:0]        inc_drops,
    input  logic              inc_recovers,
    output logic [STAT_W-1:0] stat_calls,
    output logic [STAT_W-1:0] stat_rets,
    output logic [STAT_W-1:0] stat_drops,
    output logic [STAT_W-1:0] stat_recovers
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_calls    <= '0;
            stat_rets     <= '0;
            stat_drops    <= '0;
            stat_recovers <= '0;
        end else begin
            stat_calls    <= sat_add(stat_calls, {1'b0, inc_calls});
            stat_rets     <= sat_add(stat_rets, {1'b0, inc_rets});
            stat_drops    <= sat_add(stat_drops, inc_drops);
            stat_recovers <= sat_add(stat_recovers, {1'b0, inc_recovers});
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// Initiator-side return address stack controller: turns call/return/branch fetch events and
// execute resolutions into stack commands. Statistics counters exist only with RAS_CTRL_STATS_EN.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int RET_OFS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [WIDTH-1:0]           f_pc,
    input  logic                       f_is_call,
    input  logic                       f_is_ret,
    input  logic                       f_is_branch,
    output logic                       pred_valid,
    output logic [WIDTH-1:0]           pred_target,
    input  logic                       res_valid,
    input  logic                       res_mispredict,
    output logic                       ras_push,
    output logic                       ras_pop,
    output logic                       ras_branch,
    output logic                       ras_close_valid,
    output logic                       ras_close_invalid,
    output logic [WIDTH-1:0]           ras_din,
    input  logic [WIDTH-1:0]           ras_dout,
    input  logic                       ras_empty,
    output logic [STAT_W-1:0]          stat_calls,
    output logic [STAT_W-1:0]          stat_rets,
    output logic [STAT_W-1:0]          stat_drops,
    output logic [STAT_W-1:0]          stat_recovers,
    output ras_ctrl_state_e            dbg_state,
    output logic [$clog2(DEPTH)-1:0]   dbg_occ
);

    localparam int                OCC_W   = $clog2(DEPTH);
    localparam logic [OCC_W-1:0]  OCC_MAX = OCC_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0]  OCC_ONE = OCC_W'(1);

    ras_ctrl_state_e  state_q;
    logic [OCC_W-1:0] occ_q, occ_d, ckpt_q;
    ras_cmd_t         cmd;
    logic             accept, res_ok, res_bad;

    // Fetch handshake: a slot transfers in any cycle where f_valid && f_ready; f_ready does not
    // depend on f_valid except to stall a second branch while one is still unresolved.
    always_comb begin
        res_ok  = (state_q == SPEC) && res_valid && !res_mispredict;
        res_bad = (state_q == SPEC) && res_valid && res_mispredict;
        f_ready = reset && ((state_q == IDLE) ||
                  ((state_q == SPEC) && !(f_valid && f_is_branch) && !res_bad));
        accept  = f_valid && f_ready;

        cmd               = '0;
        cmd.push          = accept && f_is_call && (occ_q < OCC_MAX);
        cmd.pop           = accept && f_is_ret && (occ_q != '0) && !ras_empty;
        cmd.branch        = accept && f_is_branch;
        cmd.close_valid   = res_ok;
        cmd.close_invalid = res_bad;

        occ_d = occ_q;
        if (cmd.push && !cmd.pop)
            occ_d = occ_q + OCC_ONE;
        else if (cmd.pop && !cmd.push)
            occ_d = occ_q - OCC_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            ckpt_q     <= '0;
            pred_valid <= 1'b0;
        end else begin
            pred_valid <= cmd.pop;
            occ_q      <= occ_d;
            case (state_q)
                IDLE: begin
                    if (cmd.branch) begin
                        ckpt_q  <= occ_d;
                        state_q <= SPEC;
                    end
                end
                SPEC: begin
                    if (res_ok) begin
                        state_q <= IDLE;
                    end else if (res_bad) begin
                        occ_q   <= ckpt_q;
                        state_q <= RECOVER;
                    end
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stack read data is only meaningful the cycle after a pop.
    assign pred_target       = pred_valid ? ras_dout : '0;
    assign ras_push          = cmd.push;
    assign ras_pop           = cmd.pop;
    assign ras_branch        = cmd.branch;
    assign ras_close_valid   = cmd.close_valid;
    assign ras_close_invalid = cmd.close_invalid;
    assign ras_din           = cmd.push ? (f_pc + WIDTH'(RET_OFS)) : '0;
    assign dbg_state         = state_q;
    assign dbg_occ           = occ_q;

`ifdef RAS_CTRL_STATS_EN
    logic call_acc, ret_acc;
    assign call_acc = accept && f_is_call;
    assign ret_acc  = accept && f_is_ret;

    ras_ctrl_stats u_stats (
        .clk           (clk),
        .reset         (reset),
        .inc_calls     (call_acc),
        .inc_rets      (ret_acc),
        .inc_drops     ({1'b0, call_acc && !cmd.push} + {1'b0, ret_acc && !cmd.pop}),
        .inc_recovers  (res_bad),
        .stat_calls    (stat_calls),
        .stat_rets     (stat_rets),
        .stat_drops    (stat_drops),
        .stat_recovers (stat_recovers)
    );
`else
    assign stat_calls    = '0;
    assign stat_rets     = '0;
    assign stat_drops    = '0;
    assign stat_recovers = '0;
`endif

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Initiator-side controller for the return address stack: drives push/pop/branch/close_valid/close_invalid/din and consumes dout/empty.
- Sits between fetch-side pre-decode and the stack; turns call/return/branch events into stack commands.
- Produces the predicted return target and tracks occupancy, including a checkpoint for the single speculative branch the stack supports.
- Sequences resolution from execute back into the stack.

Parameters:
- WIDTH, 32, address/data width.
- DEPTH, 16, stack entries; usable capacity DEPTH-1 (one slot reserved as bottom sentinel).
- RET_OFS, 4, byte offset added to f_pc to form the pushed return address.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_valid  in  1  fetch slot valid.
- f_ready  out  1  controller accepts fetch slot.
- f_pc  in  WIDTH  PC of fetched instruction.
- f_is_call  in  1  instruction is a call.
- f_is_ret  in  1  instruction is a return.
- f_is_branch  in  1  conditional branch (speculation point); never set together with call/ret.
- pred_valid  out  1  pred_target holds a stack-predicted return address.
- pred_target  out  WIDTH  predicted return target.
- res_valid  in  1  execute resolves the outstanding branch.
- res_mispredict  in  1  qualifies res_valid: 1 = wrong path.
- ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid  out  1 each  stack commands.
- ras_din  out  WIDTH  pushed return address.
- ras_dout  in  WIDTH  stack read data, valid the cycle after ras_pop.
- ras_empty  in  1  stack empty flag.
- stat_calls, stat_rets, stat_drops, stat_recovers  out  16 each  statistics (see Optional Feature).

Behaviour:
- Reset (reset=0, async): state IDLE, occupancy 0, checkpoint 0, pred_valid 0. All ras_* outputs 0 and f_ready 0 while reset is asserted. Reset mid-speculation discards the checkpoint.
- Accept = f_valid && f_ready. All ras_* commands are combinational from accept or resolution in the same cycle.
- Call accepted:
  - occupancy < DEPTH-1: ras_push=1, ras_din=f_pc+RET_OFS (mod 2^WIDTH), occupancy+1.
  - occupancy = DEPTH-1: push suppressed (overflow drop), occupancy unchanged.
- Return accepted:
  - occupancy > 0 and !ras_empty: ras_pop=1, occupancy-1. Next cycle: pred_valid=1, pred_target=ras_dout.
  - Otherwise: no pop; pred_valid stays 0 next cycle.
- Call+return together: push and pop in the same cycle, occupancy unchanged. Next-cycle pred_target is the popped value (pre-push top).
- pred_valid is a 1-cycle pulse per pop.
- State machine:
  - IDLE: f_ready=1. Branch accepted: ras_branch=1, checkpoint occupancy (post-update value of that cycle), go to SPEC. res_valid ignored.
  - SPEC: f_ready=1 unless f_is_branch is presented; a second branch stalls (f_ready=0) until resolution.
    - res_valid && !res_mispredict: ras_close_valid=1, go to IDLE. Non-branch fetch is accepted in this cycle, and a concurrent push/pop is issued alongside the close. A branch presented in this cycle is still stalled and is accepted in IDLE the next cycle.
    - res_valid && res_mispredict: ras_close_invalid=1, f_ready=0 this cycle, occupancy restored to checkpoint, go to RECOVER.
  - RECOVER: f_ready=0 for exactly one cycle while stack pointers settle, then IDLE.
- res_valid in IDLE or RECOVER is dropped.
- No command is issued unless state permits. ras_branch is never asserted in the same cycle as a close.

Optional Feature:
- Macro: RAS_CTRL_STATS_EN.
- When defined: stat_calls, stat_rets, stat_drops and stat_recovers are 16-bit saturating counters (saturate at 0xFFFF).
  - stat_calls: accepted calls.
  - stat_rets: accepted returns.
  - stat_drops: overflow drops plus empty returns.
  - stat_recovers: mispredict closes.
  - All clear on reset.
- When undefined: the ports remain and are tied to 0; no counter flops are synthesised.

Decomposition:
- Package ras_pkg:
  - ras_ctrl_state_e enum {IDLE, SPEC, RECOVER}.
  - Packed struct ras_cmd_t {push, pop, branch, close_valid, close_invalid}.
  - Localparam for the stats counter width (16).
- One sub-module, ras_ctrl_stats: saturating counter bank, instantiated only under RAS_CTRL_STATS_EN.

Test Plan:
1. Call at f_pc=0x1000, then return: ras_push with ras_din=0x1004; ras_pop next; pred_valid=1 with pred_target=0x1004 one cycle after the pop.
2. 16 calls with DEPTH=16: first 15 push, 16th drops (no ras_push). 16 returns: 15 pops with correct LIFO targets, 16th has pred_valid=0; stat_drops=2 with the macro defined.
3. Occupancy 3, branch, 2 returns, res_valid+res_mispredict: ras_close_invalid=1, f_ready low for 2 cycles (resolve and RECOVER), occupancy back to 3; next return pops the pre-branch top.
4. Branch, call at 0x2000, res_valid with res_mispredict=0 in the same cycle as a return fetch: ras_close_valid and ras_pop asserted together; state IDLE; pred_target=0x2004.
5. Second branch presented in SPEC: f_ready=0 until resolution. In the close_valid cycle the branch is still stalled; accepted in IDLE the next cycle with ras_branch=1.
6. Assert reset during SPEC with pending pred: all outputs 0 asynchronously; after release state is IDLE, occupancy 0, and a return yields no pop.
